// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
// Holds the state encoding, requester count and default parameter values.
package rr_arbiter_4_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam int unsigned NUM_REQ      = 4;
   localparam int unsigned CNT_W_DEF    = 8;
   localparam int unsigned HOLD_MAX_DEF = 16;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational rotating-priority picker.
// It returns the first set request at or after ptr, wrapping modulo 4.
module rr_pick_4
   import rr_arbiter_4_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [1:0]         pick_idx,
   output logic               pick_vld
);

   logic [1:0] cand;

   always_comb begin
      pick_idx = '0;
      pick_vld = 1'b0;
      cand     = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = ptr + 2'(k);
         if (!pick_vld && req[cand]) begin
            pick_idx = cand;
            pick_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Registered 4-requester round-robin arbiter with grant hold timeout.
// grant_idx/grant_en feed a 2-to-4 decoder's I/en inputs.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned HOLD_MAX = HOLD_MAX_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [1:0]         grant_idx,
   output logic               grant_en,
   output logic               timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [1:0]       grant_idx_d;
   logic             grant_en_d;
   logic             timeout_d;

   logic [1:0]       pick_idx;
   logic             pick_vld;
   logic             owner_req;
   logic             hold_expired;

   rr_pick_4 u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   // A drop coinciding with expiry is a normal release, so expiry needs owner_req.
   assign owner_req    = req[grant_idx];
   assign hold_expired = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LAST) && owner_req;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      grant_idx_d = grant_idx;
      grant_en_d  = grant_en;
      timeout_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d     = ST_GRANT;
               grant_idx_d = pick_idx;
               grant_en_d  = 1'b1;
               hold_cnt_d  = '0;
            end
         end
         ST_GRANT: begin
            if (hold_cnt_q != '1)
               hold_cnt_d = hold_cnt_q + 1'b1;
            if (!owner_req || hold_expired) begin
               state_d    = ST_IDLE;
               grant_en_d = 1'b0;
               ptr_d      = grant_idx + 2'd1;
               timeout_d  = hold_expired;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            grant_en_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         grant_idx  <= '0;
         grant_en   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_cnt_d;
         grant_idx  <= grant_idx_d;
         grant_en   <= grant_en_d;
         timeout    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: one default instance and one with HOLD_MAX=4,
// both compared each cycle against a grant-length reference model.
module tb_rr_arbiter_4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;

   logic [1:0] gi_a, gi_b;
   logic       ge_a, ge_b, to_a, to_b;
   logic [3:0] y_a, y_b;

   int n_total = 0;
   int n_bad   = 0;

   // Reference state per instance: busy, owner, rotation start, cycles granted so far.
   int hmax   [2] = '{16, 4};
   int m_busy [2];
   int m_idx  [2];
   int m_ptr  [2];
   int m_len  [2];
   int m_to   [2];

   always #5 clk = ~clk;

   rr_arbiter_4 dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant_idx (gi_a),
      .grant_en  (ge_a),
      .timeout   (to_a)
   );

   rr_arbiter_4 #(.CNT_W(8), .HOLD_MAX(4)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant_idx (gi_b),
      .grant_en  (ge_b),
      .timeout   (to_b)
   );

   // Stand-in for the downstream 2-to-4 decoder with enable.
   assign y_a = ge_a ? (4'b0001 << gi_a) : 4'b0000;
   assign y_b = ge_b ? (4'b0001 << gi_b) : 4'b0000;

   task automatic chk(input string tag, input int got, input int exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input int d, input logic [3:0] r, input logic rn);
      int c;
      int found;
      if (!rn) begin
         m_busy[d] = 0; m_idx[d] = 0; m_ptr[d] = 0; m_len[d] = 0; m_to[d] = 0;
      end else if (m_busy[d] == 0) begin
         m_to[d] = 0;
         found = 0;
         for (int k = 0; k < 4; k++) begin
            c = (m_ptr[d] + k) % 4;
            if (found == 0 && r[c]) begin
               found = 1; m_busy[d] = 1; m_idx[d] = c; m_len[d] = 1;
            end
         end
      end else begin
         m_to[d] = 0;
         if (!r[m_idx[d]]) begin
            m_busy[d] = 0; m_ptr[d] = (m_idx[d] + 1) % 4;
         end else if (hmax[d] != 0 && m_len[d] == hmax[d]) begin
            m_busy[d] = 0; m_ptr[d] = (m_idx[d] + 1) % 4; m_to[d] = 1;
         end else begin
            m_len[d]++;
         end
      end
   endtask

   task automatic compare_all();
      int exp_y;
      for (int d = 0; d < 2; d++) begin
         exp_y = m_busy[d] ? (1 << m_idx[d]) : 0;
         chk($sformatf("dut%0d.grant_en", d), d ? int'(ge_b) : int'(ge_a), m_busy[d]);
         chk($sformatf("dut%0d.grant_idx", d), d ? int'(gi_b) : int'(gi_a), m_idx[d]);
         chk($sformatf("dut%0d.timeout", d), d ? int'(to_b) : int'(to_a), m_to[d]);
         chk($sformatf("dut%0d.y", d), d ? int'(y_b) : int'(y_a), exp_y);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic rn);
      req   = r;
      rst_n = rn;
      @(posedge clk);
      model_edge(0, r, rn);
      model_edge(1, r, rn);
      #1;
      compare_all();
   endtask

   initial begin
      logic [3:0] r;
      logic [3:0] m;

      // Reset held with all requests asserted.
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b1111, 1'b1);

      // Single requester then drop.
      step(4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) step(4'b0100, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
      step(4'b0010, 1'b1);
      step(4'b0010, 1'b1);

      // Round-robin wrap: drop the granted bit for one cycle.
      step(4'b0000, 1'b0);
      for (int i = 0; i < 14; i++) begin
         if (m_busy[0] != 0) begin
            m = 4'b0001 << m_idx[0];
            step(4'b1111 & ~m, 1'b1);
         end else begin
            step(4'b1111, 1'b1);
         end
      end

      // Timeout alternation with two requesters held.
      step(4'b0000, 1'b0);
      for (int i = 0; i < 24; i++) step(4'b0011, 1'b1);

      // Drop in the same cycle the timeout would fire.
      step(4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) step(4'b0001, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

      // Reset during an idx 2 grant, then ptr must be back at 0.
      step(4'b0000, 1'b0);
      step(4'b0100, 1'b1);
      step(4'b0100, 1'b1);
      step(4'b0100, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0110, 1'b1);

      // Long single hold to exercise the default instance's timeout.
      step(4'b0000, 1'b0);
      for (int i = 0; i < 40; i++) step(4'b1000, 1'b1);

      // Randomized sticky requests with occasional reset.
      r = '0;
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(7) == 0) r[b] = ~r[b];
         step(r, ($urandom_range(99) != 0));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
